// File: rtl/noc_output_port_arbiter.sv
// Output-port stage of the NoC router: round-robin wormhole arbitration over
// NUM_IN input channels into one registered valid/ready output channel.
module noc_output_port_arbiter #(
  parameter int          NUM_IN     = 5,
  parameter int          DATA_WIDTH = 32,
  parameter int          LEN_WIDTH  = 12,
  parameter logic [2:0]  HDR_ID     = 3'b001
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_IN*DATA_WIDTH-1:0] req_data_in,
  input  logic [NUM_IN-1:0]            req_valid_in,
  output logic [NUM_IN-1:0]            req_ready_out,
  output logic [DATA_WIDTH-1:0]        data_out,
  output logic                         valid_out,
  input  logic                         ready_in,
  output logic [NUM_IN-1:0]            grant_out,
  output logic                         busy_out,
  output logic                         len_err_out
);

  localparam int PTR_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

  // Handshake: a flit moves on a channel in any cycle where valid and ready are
  // both high at the rising edge; ready never depends on anything but state,
  // headers presented and downstream slot availability.
  typedef enum logic {IDLE = 1'b0, FWD = 1'b1} state_t;

  state_t                 state;
  logic [LEN_WIDTH-1:0]   remaining;
  logic [PTR_W-1:0]       owner;
  logic [PTR_W-1:0]       rr_ptr;

  logic                   slot_free;
  logic [NUM_IN-1:0]      eligible;
  logic [PTR_W-1:0]       winner;
  logic [PTR_W-1:0]       cand;
  logic                   win_found;
  logic [NUM_IN-1:0]      ready;
  logic [NUM_IN-1:0]      grant;
  logic [PTR_W-1:0]       xfer_idx;
  logic                   xfer;
  logic [DATA_WIDTH-1:0]  xfer_flit;
  logic [LEN_WIDTH-1:0]   hdr_len;
  logic [LEN_WIDTH-1:0]   eff_len;

  assign slot_free = !valid_out || ready_in;

  for (genvar g = 0; g < NUM_IN; g++) begin : g_elig
    assign eligible[g] = req_valid_in[g] &&
                         (req_data_in[g*DATA_WIDTH + DATA_WIDTH-1 -: 3] == HDR_ID);
  end

  // Round-robin search starts just above the last packet's owner.
  always_comb begin
    winner    = '0;
    cand      = '0;
    win_found = 1'b0;
    for (int k = 1; k <= NUM_IN; k++) begin
      cand = PTR_W'((int'(rr_ptr) + k) % NUM_IN);
      if (!win_found && eligible[cand]) begin
        win_found = 1'b1;
        winner    = cand;
      end
    end
  end

  always_comb begin
    ready    = '0;
    grant    = '0;
    xfer_idx = owner;
    if (state == FWD) begin
      xfer_idx = owner;
      if (!rst) ready[owner] = slot_free;
      grant[owner] = 1'b1;
    end else begin
      xfer_idx = winner;
      if (!rst && win_found) ready[winner] = slot_free;
      if (!rst && win_found && slot_free) grant[winner] = 1'b1;
    end
  end

  assign req_ready_out = ready;
  assign grant_out     = grant;
  assign busy_out      = (state == FWD);
  assign xfer          = |(req_valid_in & ready);
  assign xfer_flit     = req_data_in[xfer_idx*DATA_WIDTH +: DATA_WIDTH];
  assign hdr_len       = xfer_flit[DATA_WIDTH-4 -: LEN_WIDTH];
  assign eff_len       = (hdr_len == '0) ? LEN_WIDTH'(1) : hdr_len;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      remaining   <= '0;
      owner       <= '0;
      rr_ptr      <= PTR_W'(NUM_IN - 1);
      len_err_out <= 1'b0;
    end else begin
      len_err_out <= 1'b0;
      case (state)
        IDLE: begin
          if (xfer) begin
            remaining   <= eff_len - LEN_WIDTH'(1);
            owner       <= winner;
            len_err_out <= (hdr_len == '0);
            if (eff_len <= LEN_WIDTH'(1)) rr_ptr <= winner;
            else                          state  <= FWD;
          end
        end
        FWD: begin
          if (xfer) begin
            remaining <= remaining - LEN_WIDTH'(1);
            if (remaining == LEN_WIDTH'(1)) begin
              state  <= IDLE;
              rr_ptr <= owner;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output slice: holds data_out while stalled, drops valid once drained.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out  <= '0;
      valid_out <= 1'b0;
    end else if (xfer) begin
      data_out  <= xfer_flit;
      valid_out <= 1'b1;
    end else if (ready_in) begin
      valid_out <= 1'b0;
    end
  end

endmodule
